// File: rtl/atm_keypad_frontend.sv
// Keypad front end for the ATM controller: collects PIN digit, operation and amount
// from single-cycle key strobes and issues one request through a valid/ready handshake.
module atm_keypad_frontend #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int MAX_DIGITS  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       card_in,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       req_ready,
    output logic [3:0] entered_pin,
    output logic [7:0] amount_entered,
    output logic [1:0] OP,
    output logic       req_valid,
    output logic       busy,
    output logic       abort,
    output logic [1:0] abort_cause
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_DIGITS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PIN   = 3'd1;
    localparam logic [2:0] S_OPSEL = 3'd2;
    localparam logic [2:0] S_AMT   = 3'd3;
    localparam logic [2:0] S_ISSUE = 3'd4;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    localparam logic [1:0] CAUSE_CANCEL  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_CARD    = 2'b11;

    logic [2:0]    state;
    logic          have_pin;
    logic [CW-1:0] digit_count;
    logic [TW-1:0] timer;
    logic          in_entry;
    logic          is_digit;
    logic          is_op;
    logic [11:0]   amt_calc;
    logic [7:0]    amt_sat;
    logic          abort_now;
    logic [1:0]    cause_now;

    assign in_entry  = (state == S_PIN) || (state == S_OPSEL) || (state == S_AMT);
    assign is_digit  = (key_code <= 4'd9);
    assign is_op     = (key_code >= 4'hD);
    assign amt_calc  = 12'(amount_entered) * 12'd10 + 12'(key_code);
    assign amt_sat   = (amt_calc > 12'd255) ? 8'hFF : amt_calc[7:0];
    assign req_valid = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);

    // Card removal outranks everything; a key in the expiry cycle beats the timeout.
    always_comb begin
        abort_now = 1'b0;
        cause_now = 2'b00;
        if (state != S_IDLE && !card_in) begin
            abort_now = 1'b1;
            cause_now = CAUSE_CARD;
        end else if (in_entry && key_valid && key_code == KEY_CANCEL) begin
            abort_now = 1'b1;
            cause_now = CAUSE_CANCEL;
        end else if (in_entry && !key_valid && timer == TIMER_LAST) begin
            abort_now = 1'b1;
            cause_now = CAUSE_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            have_pin       <= 1'b0;
            digit_count    <= '0;
            timer          <= '0;
            entered_pin    <= 4'd0;
            amount_entered <= 8'd0;
            OP             <= 2'b00;
            abort          <= 1'b0;
            abort_cause    <= 2'b00;
        end else begin
            abort <= abort_now;
            if (abort_now) begin
                state          <= S_IDLE;
                abort_cause    <= cause_now;
                have_pin       <= 1'b0;
                digit_count    <= '0;
                timer          <= '0;
                entered_pin    <= 4'd0;
                amount_entered <= 8'd0;
                OP             <= 2'b00;
            end else begin
                case (state)
                    S_IDLE: begin
                        timer <= '0;
                        if (card_in) state <= S_PIN;
                    end
                    S_ISSUE: begin
                        timer <= '0;
                        if (req_ready) state <= S_OPSEL;
                    end
                    S_PIN, S_OPSEL, S_AMT: begin
                        if (key_valid) begin
                            timer <= '0;
                            case (state)
                                S_PIN: begin
                                    if (is_digit) begin
                                        entered_pin <= key_code;
                                        have_pin    <= 1'b1;
                                    end else if (key_code == KEY_ENTER && have_pin) begin
                                        state <= S_OPSEL;
                                    end else if (key_code == KEY_CLEAR) begin
                                        entered_pin <= 4'd0;
                                        have_pin    <= 1'b0;
                                    end
                                end
                                S_OPSEL: begin
                                    if (is_op) begin
                                        OP             <= key_code[1:0];
                                        amount_entered <= 8'd0;
                                        digit_count    <= '0;
                                        state          <= S_AMT;
                                    end
                                end
                                S_AMT: begin
                                    if (is_digit) begin
                                        if (digit_count < CNT_MAX) begin
                                            amount_entered <= amt_sat;
                                            digit_count    <= digit_count + 1'b1;
                                        end
                                    end else if (key_code == KEY_CLEAR) begin
                                        amount_entered <= 8'd0;
                                        digit_count    <= '0;
                                    end else if (key_code == KEY_ENTER) begin
                                        state <= S_ISSUE;
                                    end else if (is_op) begin
                                        OP <= key_code[1:0];
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule
